// File: rtl/down_counter_reload.sv
// Loadable modulo down-counter with one-shot / auto-reload modes and a
// registered terminal-count pulse on the 1->0 transition.
module down_counter_reload #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             tc,
  output logic             done,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             done_q;
  logic             running_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        count_q  <= load_value;
        reload_q <= load_value;
        done_q   <= 1'b0;
        if (load_value != '0) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end else begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (enable) begin
              if (count_q == WIDTH'(1)) begin
                // auto_reload is only sampled on the expiry edge
                count_q <= '0;
                tc_q    <= 1'b1;
                if (!auto_reload) begin
                  state_q   <= DONE;
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
                end
              end else if (count_q == '0) begin
                count_q <= reload_q;
              end else begin
                count_q <= count_q - WIDTH'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign Q       = count_q;
  assign zero    = (count_q == '0);
  assign tc      = tc_q;
  assign done    = done_q;
  assign running = running_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed bench for down_counter_reload: one-shot, periodic, gating,
// load priority, asynchronous clear and mode change.
module tb_down_counter_reload;

  logic       clock;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic       auto_reload;
  logic [3:0] Q;
  logic       zero;
  logic       tc;
  logic       done;
  logic       running;

  int n_assert = 0;
  int n_fail   = 0;

  down_counter_reload #(.WIDTH(4)) dut (
    .clock      (clock),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .auto_reload(auto_reload),
    .Q          (Q),
    .zero       (zero),
    .tc         (tc),
    .done       (done),
    .running    (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] eq, input logic etc,
                     input logic edone, input logic erun);
    chk1({tag, ".Q"},       32'(Q),       32'(eq));
    chk1({tag, ".zero"},    32'(zero),    32'(eq == 4'd0));
    chk1({tag, ".tc"},      32'(tc),      32'(etc));
    chk1({tag, ".done"},    32'(done),    32'(edone));
    chk1({tag, ".running"}, 32'(running), 32'(erun));
  endtask

  initial begin
    clear = 1'b1; load = 1'b0; load_value = 4'd0; enable = 1'b0; auto_reload = 1'b0;
    #2;
    chk("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("reset_edge", 4'd0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;

    // 1: one-shot from 5
    load = 1'b1; load_value = 4'd5; auto_reload = 1'b0;
    tick();
    load = 1'b0;
    chk("os_load", 4'd5, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk("os_cnt", 4'(i), 1'b0, 1'b0, 1'b1);
    end
    tick();
    chk("os_expire", 4'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("os_hold", 4'd0, 1'b0, 1'b1, 1'b0);
    end

    // 2: periodic from 3, enable held high through the load
    load = 1'b1; load_value = 4'd3; auto_reload = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    chk("per_load", 4'd3, 1'b0, 1'b0, 1'b1);
    begin
      logic [3:0] seq [8] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
      for (int i = 0; i < 8; i++) begin
        tick();
        chk("per_seq", seq[i], seq[i] == 4'd0, 1'b0, 1'b1);
      end
    end

    // 3: enable gating
    load = 1'b1; load_value = 4'd4; auto_reload = 1'b0; enable = 1'b0;
    tick();
    load = 1'b0;
    chk("gate_load", 4'd4, 1'b0, 1'b0, 1'b1);
    begin
      logic       en  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] seq [6] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
      for (int i = 0; i < 6; i++) begin
        enable = en[i];
        tick();
        chk("gate_seq", seq[i], i == 5, i == 5, i != 5);
      end
    end

    // 4: load priority mid-count, load of 0, load of 15 periodic
    load = 1'b1; load_value = 4'd5; auto_reload = 1'b0; enable = 1'b1;
    tick();
    load = 1'b0;
    chk("pri_load5", 4'd5, 1'b0, 1'b0, 1'b1);
    for (int i = 4; i >= 2; i--) begin
      tick();
      chk("pri_cnt", 4'(i), 1'b0, 1'b0, 1'b1);
    end
    load = 1'b1; load_value = 4'd9;
    tick();
    chk("pri_load9", 4'd9, 1'b0, 1'b0, 1'b1);
    load_value = 4'd0;
    tick();
    load = 1'b0;
    chk("load0", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load0_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    load = 1'b1; load_value = 4'd15; auto_reload = 1'b1;
    tick();
    load = 1'b0;
    chk("max_load", 4'd15, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("max_cnt", 4'(15 - i), i == 15, 1'b0, 1'b1);
    end
    tick();
    chk("max_reload", 4'd15, 1'b0, 1'b0, 1'b1);

    // 5: asynchronous clear between edges
    load = 1'b1; load_value = 4'd6; enable = 1'b0;
    tick();
    load = 1'b0;
    chk("ar_load", 4'd6, 1'b0, 1'b0, 1'b1);
    #3;
    clear = 1'b1;
    #1;
    chk("ar_async", 4'd0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    enable = 1'b1;
    tick();
    chk("ar_idle1", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar_idle2", 4'd0, 1'b0, 1'b0, 1'b0);

    // 6: drop auto_reload mid-period, then resume periodic
    load = 1'b1; load_value = 4'd3; auto_reload = 1'b1;
    tick();
    load = 1'b0;
    chk("mc_load", 4'd3, 1'b0, 1'b0, 1'b1);
    tick();
    chk("mc_q2", 4'd2, 1'b0, 1'b0, 1'b1);
    auto_reload = 1'b0;
    tick();
    chk("mc_q1", 4'd1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("mc_expire", 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("mc_noreload", 4'd0, 1'b0, 1'b1, 1'b0);
    load = 1'b1; load_value = 4'd2; auto_reload = 1'b1;
    tick();
    load = 1'b0;
    chk("mc_reload", 4'd2, 1'b0, 1'b0, 1'b1);
    begin
      logic [3:0] seq [5] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("mc_per", seq[i], seq[i] == 4'd0, 1'b0, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter_reload.md
Name: down_counter_reload

Overview:
Synchronous, loadable, modulo down-counter with terminal-count pulse, one-shot and auto-reload modes. It is the counting-down counterpart to the team's 4-bit ripple up-counter. It serves as the programmable timer/divider in the same designs: a host loads a period, and the block counts it out and flags expiry. All state changes on the rising edge of clock, so there are no ripple-clock paths.

Parameters:
WIDTH, 4, bit width of the count, the load value and the internal reload register

Ports:
clock  input  1  single system clock; all state updates on the rising edge
clear  input  1  asynchronous, active-high reset
load  input  1  when high, the count and reload register take load_value at the next edge
load_value  input  WIDTH  period value, unsigned
enable  input  1  count-down qualifier
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode
Q  output  WIDTH  current count (registered)
zero  output  1  combinational, (Q == 0)
tc  output  1  registered terminal-count pulse
done  output  1  registered; one-shot expiry level
running  output  1  registered; high while state is RUN

Behaviour:
- Reset: clock has one domain; reset is asynchronous and active-high (port clear).
- While clear is high:
  - Q=0, reload register=0, state=IDLE.
  - tc=0, done=0, running=0; zero therefore reads 1.
- States are IDLE, RUN and DONE. running = (state==RUN). done = (state==DONE).
- Priority, highest first: clear, then load, then enable.
- load=1, in any state, regardless of enable:
  - Q and the reload register take load_value; tc=0.
  - If load_value != 0, next state is RUN. If load_value == 0, next state is IDLE and Q=0 with no tc.
- IDLE: Q holds. enable is ignored. Leaves IDLE only on load.
- RUN with enable=0: Q holds, state holds, tc=0.
- RUN with enable=1 and Q > 1: Q <= Q-1, tc=0.
- RUN with enable=1 and Q == 1 (expiry):
  - Q <= 0 and tc <= 1; tc is high in exactly the cycle Q first reads 0.
  - auto_reload is sampled at this edge. If it is 1, state stays RUN. If it is 0, state goes to DONE.
- RUN with enable=1 and Q == 0 (only reachable in periodic mode): Q <= reload register, tc <= 0. auto_reload is not re-sampled at this edge.
- Periodic timing: with continuous enable, the period is N+1 enabled cycles for load_value N. The sequence is N, N-1, …, 1, 0, N, …, with one tc pulse per period.
- DONE: Q holds 0, done=1. enable and auto_reload are ignored. Leaves DONE only on load (or clear).
- tc is never high for two consecutive cycles. tc is low on any cycle whose edge did not perform a 1→0 transition.
- Arithmetic: unsigned, modulo 2^WIDTH. No underflow is possible, because decrement occurs only from Q ≥ 1.
- Maximum load value 2^WIDTH-1 (15 for WIDTH=4) is legal. It gives a 16-cycle period in periodic mode.
- Reset mid-operation: clear asserted asynchronously forces the reset values immediately, independent of clock. After clear deasserts, the block sits in IDLE until a load.
- The reload register is written only by load or clear.

Test Plan:
1. One-shot: WIDTH=4, load 5 with auto_reload=0, then enable=1 continuously → Q reads 5,4,3,2,1,0. tc is high only in the cycle Q=0. done rises with that same edge; running falls. Q stays 0 for the next 10 cycles with no further tc.
2. Periodic: load 3 with auto_reload=1 and continuous enable → Q reads 3,2,1,0,3,2,1,0,3. tc pulses every 4 cycles, done stays 0 and running stays 1 throughout.
3. Enable gating: load 4, then pattern enable=1,0,0,1,1,1 → Q reads 4,3,3,3,2,1,0. The tc pulse appears only with Q=0. Q holds during the enable=0 cycles.
4. Load priority and edge values:
   - Mid-count (Q=2), assert load=1 with load_value=9 and enable=1 → next Q=9, tc=0.
   - load_value=0 → Q=0, state IDLE, running=0, done=0, tc=0.
   - load_value=15 in periodic mode → period of 16 cycles.
5. Asynchronous reset: in RUN at Q=6, pulse clear between clock edges → Q=0 and running=0 before the next edge. Afterwards, enable=1 leaves Q=0 until a load.
6. Mode change: in periodic RUN, drop auto_reload to 0 while Q=2 → the next expiry goes to DONE, done=1, and no reload occurs. Re-load 2 with auto_reload=1 → periodic operation resumes.
